fifo_syn_ext: RTL

Parametrised single-clock FIFO: the next generation of the team's 8x8 synchronous FIFO. Width, depth and read mode are configurable, and it adds a fill count, programmable almost-full/almost-empty thresholds and optional sticky error flags. It sits between same-clock producer/consumer stages wherever buffering with back-pressure status is needed.

---
 rtl/fifo_syn_ext.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_syn_ext.sv
// fifo_syn_ext -- parametrised single-clock FIFO with fill count,
// programmable almost-full/almost-empty thresholds and optional sticky
// error flags.
//
// Optional feature macro: FIFO_SYN_ERR_EN
//   defined   -> overflow/underflow sticky flags and err_clr port exist
//   undefined -> dropped requests are silently ignored, no error ports
//
// Parameters:
//   WIDTH     data word width (>= 1)
//   AW        address width, depth = 2**AW (>= 1)
//   AFULL_TH  almost_full  when count >= AFULL_TH  (1 .. 2**AW)
//   AEMPTY_TH almost_empty when count <= AEMPTY_TH (0 .. 2**AW-1)
//   FWFT      0 = registered read, 1 = first-word fall-through
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   wr, data     write request and write data
//   rd           read request (pop of the head word when FWFT=1)
//   q            read data
//   full, empty, almost_full, almost_empty, count
//                status, decoded from the pointer registers only
//   overflow     sticky: write attempted while full   (macro only)
//   underflow    sticky: read attempted while empty   (macro only)
//   err_clr      synchronous clear of both error flags (macro only)
module fifo_syn_ext #(
  parameter int WIDTH     = 8,
  parameter int AW        = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] data,
  input  logic             rd,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count
`ifdef FIFO_SYN_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
`endif
);

  localparam int          DEPTH      = 1 << AW;
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_TH);

  // Storage is deliberately not reset so it maps onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_ok, rd_ok;

  assign wr_addr = wr_ptr_reg[AW-1:0];
  assign rd_addr = rd_ptr_reg[AW-1:0];

  // Status: combinational from the pointer registers only.
  assign count        = wr_ptr_reg - rd_ptr_reg;
  assign empty        = (wr_ptr_reg == rd_ptr_reg);
  assign full         = (wr_addr == rd_addr) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign almost_full  = (count >= AFULL_LVL);
  assign almost_empty = (count <= AEMPTY_LVL);

  // Acceptance looks only at pre-edge full/empty, so a write into a full
  // FIFO is dropped even when a read frees a slot in the same cycle.
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (wr_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_ok) rd_ptr_next = rd_ptr_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; meaningless while empty.
      assign q = mem[rd_addr];
    end else begin : g_reg_read
      logic [WIDTH-1:0] q_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q_reg <= '0;
        else if (rd_ok) q_reg <= mem[rd_addr];
      end
      assign q = q_reg;
    end
  endgenerate

`ifdef FIFO_SYN_ERR_EN
  logic overflow_reg, underflow_reg;

  // A new error in the same cycle as err_clr wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr & full)   overflow_reg <= 1'b1;
      else if (err_clr) overflow_reg <= 1'b0;
      if (rd & empty)  underflow_reg <= 1'b1;
      else if (err_clr) underflow_reg <= 1'b0;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule
